bitwise_pipe_unit: RTL and testbench
====================================

BITWISE_PIPE_UNIT -- requirements
Module: bitwise_pipe_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and result width in bits, legal range 1..64.
REQ-002 SHALL have parameter PARITY_ODD, default 0: 0 makes parity flag the even-parity bit (XOR-reduce); 1 makes it the odd-parity bit (XNOR-reduce).
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port a, input, WIDTH: operand A.
REQ-006 SHALL have port b, input, WIDTH: operand B.
REQ-007 SHALL have port op, input, 3: operation select.
REQ-008 SHALL have port in_valid, input, 1: a/b/op are valid this cycle.
REQ-009 SHALL have port in_ready, output, 1: unit accepts input this cycle.
REQ-010 SHALL have port out, output, WIDTH: result.
REQ-011 SHALL have port zero, output, 1: out is all zeros.
REQ-012 SHALL have port parity, output, 1: parity flag of out per PARITY_ODD.
REQ-013 SHALL have port out_valid, output, 1: out/zero/parity valid.
REQ-014 SHALL have port out_ready, input, 1: downstream accepts result.
REQ-015 SHALL have port count, output, 16: number of results delivered since reset.

Function
REQ-016 SHALL decode op bitwise per bit i: 000 a&b; 001 a|b; 010 a^b; 011 ~(a&b); 100 ~(a|b); 101 ~(a^b); 110 a&~b; 111 ~a (b ignored).
REQ-017 SHALL be a two-stage pipeline: S1 registers a, b, op; S2 registers computed result, zero, parity.
REQ-018 SHALL accept an input on a rising edge where in_valid=1 and in_ready=1; no other edge captures input.
REQ-019 SHALL present a result with out_valid=1 two edges after acceptance when out_ready stays 1 (latency 2, throughput 1 per cycle).
REQ-020 SHALL deliver a result on a rising edge where out_valid=1 and out_ready=1; count increments by 1 on that edge.
REQ-021 SHALL drive in_ready = !S1_valid || !S2_valid || out_ready, combinationally, with no dependency on in_valid.
REQ-022 SHALL advance S1 into S2 on an edge when S1_valid=1 and (S2_valid=0 or out_ready=1).
REQ-023 SHALL hold S2 contents (out, zero, parity) stable while out_valid=1 and out_ready=0.
REQ-024 SHALL hold S1 contents stable while S1 is full and cannot advance; inputs presented then are not captured.
REQ-025 SHALL permit simultaneous accept, S1->S2 advance and output delivery on the same edge with no loss or duplication.
REQ-026 SHALL wrap count from 16'hFFFF to 16'h0000 on the next delivery.
REQ-027 SHALL compute zero and parity from the same S2 result that drives out.
REQ-028 SHALL preserve order: results emerge in acceptance order.

Reset
REQ-029 SHALL, while reset=1, force S1_valid=0, S2_valid=0, out=0, zero=1, parity=PARITY_ODD, out_valid=0, count=0, independent of clk.
REQ-030 SHALL drive in_ready=1 while reset=1 and on the first cycle after reset release, but SHALL not capture input while reset=1.
REQ-031 SHALL discard any in-flight S1/S2 data when reset asserts mid-operation; no stale result appears after release.

Verification
REQ-032 Bench SHALL check: WIDTH=32, op=010, a=32'hFFFF0000, b=32'h0F0F0F0F, out_ready=1 -> two edges later out=32'hF0F00F0F, zero=0, parity=0, count=1.
REQ-033 Bench SHALL check: op=010, a=b=32'hFFFFFFFF -> out=0, zero=1, parity=0; op=011 with same operands -> out=0, zero=1.
REQ-034 Bench SHALL check: out_ready=0 with 3 back-to-back valid inputs -> first two accepted, in_ready=0 on third, out holds first result; out_ready=1 -> three results in order, count=3.
REQ-035 Bench SHALL check: every op 000..111 on a=32'hA5A5A5A5, b=32'h3C3C3C3C matches REQ-016, including op=111 giving 32'h5A5A5A5A.
REQ-036 Bench SHALL check: reset asserted between clock edges with two items in flight -> out_valid=0, count=0 immediately; after release no result appears until new input.
REQ-037 Bench SHALL check: WIDTH=8, PARITY_ODD=1, op=001, a=8'h01, b=8'h02 -> out=8'h03, parity=1; count preset by 65535 deliveries wraps to 0 on the next.

Source files
------------

// File: rtl/bitwise_pipe_unit.sv
// Two-stage bitwise logic unit with valid/ready handshaking on both sides.
// S1 holds the captured operands; S2 holds the result with its zero and parity flags.
module bitwise_pipe_unit #(
    parameter int WIDTH      = 32,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             zero,
    output logic             parity,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      count
);

    localparam logic PAR_RST = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

    function automatic logic [WIDTH-1:0] bit_op(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y,
                                                input logic [2:0]       sel);
        logic [WIDTH-1:0] r;
        case (sel)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = x ^ y;
            3'b011:  r = ~(x & y);
            3'b100:  r = ~(x | y);
            3'b101:  r = ~(x ^ y);
            3'b110:  r = x & ~y;
            3'b111:  r = ~x;
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Odd mode yields the bit that makes the total number of ones odd.
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return (PARITY_ODD != 0) ? ~(^v) : (^v);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    logic [2:0]       s1_op_q, s1_op_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d;
    logic             s2_zero_q, s2_zero_d;
    logic             s2_par_q, s2_par_d;
    logic [15:0]      count_q, count_d;

    logic             in_ready_s;
    logic             s1_take_s;
    logic             s2_take_s;
    logic             deliver_s;
    logic [WIDTH-1:0] res_s;

    // Handshake decisions and next-state for both stages and the delivery counter.
    always_comb begin
        in_ready_s = !s1_valid_q || !s2_valid_q || out_ready;
        s1_take_s  = in_valid && in_ready_s;
        s2_take_s  = s1_valid_q && (!s2_valid_q || out_ready);
        deliver_s  = s2_valid_q && out_ready;
        res_s      = bit_op(s1_a_q, s1_b_q, s1_op_q);

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        if (s1_take_s) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = op;
        end else if (s2_take_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        s2_valid_d = s2_valid_q;
        s2_res_d   = s2_res_q;
        s2_zero_d  = s2_zero_q;
        s2_par_d   = s2_par_q;
        if (s2_take_s) begin
            s2_valid_d = 1'b1;
            s2_res_d   = res_s;
            s2_zero_d  = (res_s == {WIDTH{1'b0}});
            s2_par_d   = parity_of(res_s);
        end else if (deliver_s) begin
            s2_valid_d = 1'b0;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        if (deliver_s) begin
            count_d = count_q + 16'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Pipeline and counter state; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {WIDTH{1'b0}};
            s1_b_q     <= {WIDTH{1'b0}};
            s1_op_q    <= 3'b000;
            s2_valid_q <= 1'b0;
            s2_res_q   <= {WIDTH{1'b0}};
            s2_zero_q  <= 1'b1;
            s2_par_q   <= PAR_RST;
            count_q    <= 16'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_zero_q  <= s2_zero_d;
            s2_par_q   <= s2_par_d;
            count_q    <= count_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out       = s2_res_q;
    assign zero      = s2_zero_q;
    assign parity    = s2_par_q;
    assign out_valid = s2_valid_q;
    assign count     = count_q;

endmodule

// File: tb/tb_bitwise_pipe_unit.sv
// Self-checking bench: directed scenarios plus random traffic against an in-order scoreboard.
module tb_bitwise_pipe_unit;

    logic        clk = 1'b0;
    logic        reset;

    logic [31:0] a32, b32, out32;
    logic [2:0]  op32;
    logic        iv32, ir32, z32, p32, ov32, or32;
    logic [15:0] cnt32;

    logic [7:0]  a8, b8, out8;
    logic [2:0]  op8;
    logic        iv8, ir8, z8, p8, ov8, or8;
    logic [15:0] cnt8;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] q[$];
    logic [15:0] exp_cnt = 16'd0;
    logic [31:0] op_tab[8];
    int          del8;

    always #5 clk = ~clk;

    bitwise_pipe_unit #(.WIDTH(32), .PARITY_ODD(0)) dut32 (
        .clk(clk), .reset(reset), .a(a32), .b(b32), .op(op32),
        .in_valid(iv32), .in_ready(ir32), .out(out32), .zero(z32),
        .parity(p32), .out_valid(ov32), .out_ready(or32), .count(cnt32)
    );

    bitwise_pipe_unit #(.WIDTH(8), .PARITY_ODD(1)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .op(op8),
        .in_valid(iv8), .in_ready(ir8), .out(out8), .zero(z8),
        .parity(p8), .out_valid(ov8), .out_ready(or8), .count(cnt8)
    );

    function automatic logic [31:0] ref32(input logic [31:0] x, input logic [31:0] y,
                                          input logic [2:0] s);
        case (s)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return ~(x & y);
            3'd4:    return ~(x | y);
            3'd5:    return ~(x ^ y);
            3'd6:    return x & ~y;
            default: return ~x;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] aa, input logic [31:0] bb,
                         input logic [2:0] oo, input logic rdy);
        iv32 = v; a32 = aa; b32 = bb; op32 = oo; or32 = rdy;
        #1;
    endtask

    // Score the handshakes of the coming edge, then advance one clock.
    task automatic tick();
        logic        acc, del;
        logic [31:0] e;
        acc = iv32 && ir32;
        del = ov32 && or32;
        if (del) begin
            if (q.size() == 0) begin
                chk("unexpected_out", {63'd0, ov32}, 64'd0);
            end else begin
                e = q.pop_front();
                chk("out", {32'd0, out32}, {32'd0, e});
                chk("zero", {63'd0, z32}, {63'd0, (e == 32'd0)});
                chk("parity", {63'd0, p32}, 64'($countones(e) % 2));
                exp_cnt = exp_cnt + 16'd1;
            end
        end
        if (acc) q.push_back(ref32(a32, b32, op32));
        @(posedge clk);
        #1;
        chk("count", {48'd0, cnt32}, {48'd0, exp_cnt});
    endtask

    task automatic do_reset();
        iv32 = 1'b0;
        iv8  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, ov32}, 64'd0);
        chk("rst_count", {48'd0, cnt32}, 64'd0);
        chk("rst_out", {32'd0, out32}, 64'd0);
        chk("rst_zero", {63'd0, z32}, 64'd1);
        chk("rst_in_ready", {63'd0, ir32}, 64'd1);
        q.delete();
        exp_cnt = 16'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        op_tab = '{32'h24242424, 32'hBDBDBDBD, 32'h99999999, 32'hDBDBDBDB,
                   32'h42424242, 32'h66666666, 32'h81818181, 32'h5A5A5A5A};
        iv32 = 1'b1; a32 = 32'h12345678; b32 = 32'h0; op32 = 3'b001; or32 = 1'b1;
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; op8 = 3'b001; or8 = 1'b1;

        // Reset values, with in_valid held high across reset edges.
        #12;
        chk("init_out_valid", {63'd0, ov32}, 64'd0);
        chk("init_count", {48'd0, cnt32}, 64'd0);
        chk("init_zero", {63'd0, z32}, 64'd1);
        chk("init_parity_even", {63'd0, p32}, 64'd0);
        chk("init_parity_odd", {63'd0, p8}, 64'd1);
        chk("init_zero8", {63'd0, z8}, 64'd1);
        chk("init_in_ready", {63'd0, ir32}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        iv32 = 1'b0;
        iv8 = 1'b0;
        #1;
        chk("release_in_ready", {63'd0, ir32}, 64'd1);
        @(posedge clk);
        #1;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("no_capture_in_reset", {63'd0, ov32}, 64'd0);
            tick();
        end

        // XOR example with latency 2.
        drive(1'b1, 32'hFFFF0000, 32'h0F0F0F0F, 3'b010, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        chk("lat1_out_valid", {63'd0, ov32}, 64'd0);
        tick();
        chk("lat2_out_valid", {63'd0, ov32}, 64'd1);
        chk("xor_out", {32'd0, out32}, {32'd0, 32'hF0F00F0F});
        chk("xor_zero", {63'd0, z32}, 64'd0);
        chk("xor_parity", {63'd0, p32}, 64'd0);
        tick();
        chk("xor_count", {48'd0, cnt32}, 64'd1);

        // All-ones operands give zero results for XOR and NAND.
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b010, 1'b1);
        tick();
        drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'b011, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        chk("ones_xor_out", {32'd0, out32}, 64'd0);
        chk("ones_xor_zero", {63'd0, z32}, 64'd1);
        chk("ones_xor_parity", {63'd0, p32}, 64'd0);
        tick();
        chk("ones_nand_out", {32'd0, out32}, 64'd0);
        chk("ones_nand_zero", {63'd0, z32}, 64'd1);
        tick();

        // Backpressure: two accepted, third stalled, then released in order.
        do_reset();
        drive(1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 3'b000, 1'b0);
        chk("bp_ready1", {63'd0, ir32}, 64'd1);
        tick();
        drive(1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 3'b001, 1'b0);
        chk("bp_ready2", {63'd0, ir32}, 64'd1);
        tick();
        drive(1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 3'b010, 1'b0);
        chk("bp_ready3", {63'd0, ir32}, 64'd0);
        tick();
        chk("bp_valid", {63'd0, ov32}, 64'd1);
        chk("bp_hold1", {32'd0, out32}, {32'd0, 32'h24242424});
        tick();
        chk("bp_hold2", {32'd0, out32}, {32'd0, 32'h24242424});
        drive(1'b1, 32'hA5A5A5A5, 32'h3C3C3C3C, 3'b010, 1'b1);
        chk("bp_ready_release", {63'd0, ir32}, 64'd1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        tick();
        tick();
        tick();
        chk("bp_count3", {48'd0, cnt32}, 64'd3);

        // Every op on A5/3C, checked against literal expectations at full rate.
        for (int i = 0; i < 10; i++) begin
            drive(i < 8, 32'hA5A5A5A5, 32'h3C3C3C3C, 3'(i), 1'b1);
            if (i >= 2) begin
                chk("op_valid", {63'd0, ov32}, 64'd1);
                chk("op_table", {32'd0, out32}, {32'd0, op_tab[i-2]});
            end
            tick();
        end

        // Reset between edges with two items in flight.
        drive(1'b1, 32'h11111111, 32'h22222222, 3'b001, 1'b0);
        tick();
        drive(1'b1, 32'h33333333, 32'h44444444, 3'b010, 1'b0);
        tick();
        do_reset();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            chk("no_stale_after_reset", {63'd0, ov32}, 64'd0);
            tick();
        end

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, $urandom,
                  3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 3'b000, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (q.size() != 0) tick();
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
        tick();
        tick();

        // Narrow odd-parity instance and counter wrap.
        iv8 = 1'b1; a8 = 8'h01; b8 = 8'h02; op8 = 3'b001; or8 = 1'b1;
        @(posedge clk);
        #1;
        iv8 = 1'b0;
        @(posedge clk);
        #1;
        chk("w8_valid", {63'd0, ov8}, 64'd1);
        chk("w8_out", {56'd0, out8}, {56'd0, 8'h03});
        chk("w8_parity", {63'd0, p8}, 64'd1);
        chk("w8_zero", {63'd0, z8}, 64'd0);
        @(posedge clk);
        #1;
        chk("w8_count1", {48'd0, cnt8}, 64'd1);
        del8 = 1;
        iv8 = 1'b1;
        for (int i = 0; i < 70000; i++) begin
            if (del8 == 65535) break;
            if (ov8 && or8) del8++;
            @(posedge clk);
            #1;
        end
        chk("wrap_preset", {48'd0, cnt8}, {48'd0, 16'hFFFF});
        chk("wrap_pending", {63'd0, ov8}, 64'd1);
        @(posedge clk);
        #1;
        chk("wrap_to_zero", {48'd0, cnt8}, 64'd0);
        iv8 = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
